// File: rtl/rand_arbiter.sv
// Round-robin arbiter that hands out one 32-bit Fibonacci LFSR word per grant.
// The LFSR steps once per grant, so every requester gets a distinct word.
module rand_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WARMUP_CYCLES = 16,
  parameter int FREE_RUN      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [31:0]        seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        rnd_out,
  output logic               ready
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WLAST = CW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  localparam logic [0:0] WARMUP = 1'b0;
  localparam logic [0:0] SERVE  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d, lfsr_nx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]        rnd_q, rnd_d;
  logic [PW-1:0]      win, cand;
  logic               found;

  // All-zero state would lock the LFSR, so it escapes to all-ones.
  always_comb begin
    if (lfsr_q == '0) lfsr_nx = '1;
    else              lfsr_nx = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    if (seed_load) begin
      lfsr_d  = (seed == '0) ? '1 : seed;
      state_d = WARMUP;
      cnt_d   = '0;
    end else if (state_q == WARMUP) begin
      if (WARMUP_CYCLES == 0) begin
        state_d = SERVE;
      end else begin
        lfsr_d = lfsr_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == WLAST) state_d = SERVE;
      end
    end else if (found) begin
      gnt_d  = NUM_REQ'(1) << win;
      rnd_d  = lfsr_q;
      lfsr_d = lfsr_nx;
      ptr_d  = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (FREE_RUN != 0) begin
      lfsr_d = lfsr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      lfsr_q  <= '1;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
    end
  end

  assign gnt     = gnt_q;
  assign rnd_out = rnd_q;
  assign ready   = (state_q == SERVE);

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed bench for rand_arbiter: three instances cover no-warm-up,
// 16-cycle warm-up and free-running LFSR configurations.
module tb_rand_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, seed_load;
  logic [31:0] seed;
  logic [3:0]  req_a, req_b, req_c;
  logic [3:0]  gnt_a, gnt_b, gnt_c;
  logic [31:0] rnd_a, rnd_b, rnd_c;
  logic        rdy_a, rdy_b, rdy_c;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rand_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(0), .FREE_RUN(0)) u_a (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .req(req_a), .gnt(gnt_a), .rnd_out(rnd_a), .ready(rdy_a));
  rand_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(16), .FREE_RUN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .req(req_b), .gnt(gnt_b), .rnd_out(rnd_b), .ready(rdy_b));
  rand_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(0), .FREE_RUN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .req(req_c), .gnt(gnt_c), .rnd_out(rnd_c), .ready(rdy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] seq1 [5];
    logic [3:0]  rr_g [5];
    seq1 = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'hFFFF_FFF6};
    rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n = 1'b0; seed_load = 1'b0; seed = '0;
    req_a = '0; req_b = '0; req_c = '0;
    tick();
    chk("reset_gnt", gnt_a, 0);
    chk("reset_rnd", rnd_a, 0);
    chk("reset_ready", rdy_a, 0);
    chk("reset_ready_b", rdy_b, 0);

    // Single requester streaming, warm-up timing, free-run idle stepping
    rst_n = 1'b1; req_a = 4'b0001; req_b = 4'b0010;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n == 1) begin
        chk("a_ready", rdy_a, 1);
        chk("a_gnt_warm", gnt_a, 0);
      end
      if (n >= 2 && n <= 6) begin
        chk("a_stream_gnt", gnt_a, 4'b0001);
        chk("a_stream_rnd", rnd_a, seq1[n-2]);
      end
      if (n == 5) req_c = 4'b0001;
      if (n == 6) begin
        req_a = '0;
        req_c = '0;
        chk("c_freerun_rnd", rnd_c, 32'hFFFF_FFF6);
        chk("c_freerun_gnt", gnt_c, 4'b0001);
      end
      if (n == 7) chk("a_idle_gnt", gnt_a, 0);
      if (n <= 15) begin
        chk("b_warm_ready", rdy_b, 0);
        chk("b_warm_gnt", gnt_b, 0);
      end
      if (n == 16) chk("b_ready", rdy_b, 1);
      if (n == 17) begin
        chk("b_first_gnt", gnt_b, 4'b0010);
        req_b = '0;
      end
    end

    // Round-robin across four requesters
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req_a = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", gnt_a, rr_g[k]);
      chk("rr_rnd", rnd_a, seq1[k]);
      req_a = req_a & ~gnt_a;
      if (k == 3) req_a = 4'b1111;
      if (k == 4) req_a = '0;
    end

    // Seed load, including zero seed
    seed = 32'h0000_0001; seed_load = 1'b1;
    tick();
    chk("seed_ready", rdy_a, 0);
    chk("seed_gnt", gnt_a, 0);
    seed_load = 1'b0; req_a = 4'b0001;
    tick();
    tick(); chk("seed1_rnd0", rnd_a, 32'h0000_0001);
    tick(); chk("seed1_rnd1", rnd_a, 32'h0000_0003);
    tick(); chk("seed1_rnd2", rnd_a, 32'h0000_0006);
    req_a = '0; seed = '0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; req_a = 4'b0001;
    tick();
    tick(); chk("seed0_rnd", rnd_a, 32'hFFFF_FFFF);
    req_a = '0;

    // Seed load in the middle of warm-up restarts the count
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req_b = 4'b0010;
    for (int n = 1; n <= 8; n++) tick();
    seed = 32'h1234_5678; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("b_reseed_ready", rdy_b, 0);
    for (int m = 1; m <= 17; m++) begin
      tick();
      if (m < 16) chk("b_rewarm_ready", rdy_b, 0);
      if (m == 16) chk("b_rewarm_done", rdy_b, 1);
      if (m == 17) chk("b_rewarm_gnt", gnt_b, 4'b0010);
    end
    req_b = '0;

    // Seed load beats a simultaneous request
    seed = 32'hA5A5_A5A5; seed_load = 1'b1; req_a = 4'b0100;
    tick();
    chk("sim_seed_gnt", gnt_a, 0);
    chk("sim_seed_ready", rdy_a, 0);
    seed_load = 1'b0;
    tick();
    tick();
    chk("sim_seed_gnt2", gnt_a, 4'b0100);
    chk("sim_seed_rnd", rnd_a, 32'hA5A5_A5A5);
    req_a = '0;

    // Reset beats seed load; then idle cycles with and without free-run
    rst_n = 1'b0; seed_load = 1'b1; seed = 32'h0000_0005;
    tick();
    chk("rst_seed_ready", rdy_a, 0);
    chk("rst_seed_rnd", rnd_a, 0);
    rst_n = 1'b1; seed_load = 1'b0;
    for (int n = 1; n <= 5; n++) tick();
    req_a = 4'b0001; req_c = 4'b0001;
    tick();
    chk("rst_seed_first_rnd", rnd_a, 32'hFFFF_FFFF);
    chk("idle_nofree_gnt", gnt_a, 4'b0001);
    chk("idle_free_rnd", rnd_c, 32'hFFFF_FFF6);
    req_a = '0; req_c = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
